// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-player score keeper with game FSM and 4-digit 7-segment scan
//
// Ports:
//   clk        system clock, the only clock
//   rst        asynchronous reset, active low
//   lose1      player 1 missed (asynchronous level, from the display domain)
//   lose2      player 2 missed (asynchronous level, from the display domain)
//   new_game   raw push-button level; a rising edge starts a new game
//   p1_score   player 1 score, 0..WIN_SCORE
//   p2_score   player 2 score, 0..WIN_SCORE
//   game_over  high while the game is over
//   winner     01 = player 1 won, 10 = player 2 won, 00 = none
//   an         7-segment anodes, active low, one-hot
//   seg        7-segment cathodes, active low, seg[0]=a .. seg[6]=g
//   dp         decimal point, active low, held off

module score_keeper #(
    parameter int WIN_SCORE = 9,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_ROT = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lose1,
    input  logic       lose2,
    input  logic       new_game,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ROT_W  = (BLINK_ROT > 1) ? $clog2(BLINK_ROT) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. Bit order: {new_game, lose2, lose1}.
    // All flops reset to 1 so an input that is already high when reset
    // is released never looks like a fresh rising edge.
    // ------------------------------------------------------------------
    logic [2:0] in_raw;
    logic [2:0] in_meta;
    logic [2:0] in_sync;
    logic [2:0] in_hist;
    logic [2:0] in_event;

    assign in_raw   = {new_game, lose2, lose1};
    assign in_event = in_sync & ~in_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_meta <= 3'b111;
            in_sync <= 3'b111;
            in_hist <= 3'b111;
        end else begin
            in_meta <= in_raw;
            in_sync <= in_meta;
            in_hist <= in_sync;
        end
    end

    logic ev_lose1;
    logic ev_lose2;
    logic ev_new;

    assign ev_lose1 = in_event[0];
    assign ev_lose2 = in_event[1];
    assign ev_new   = in_event[2];

    // ------------------------------------------------------------------
    // Game FSM and score registers
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_next;
    logic [3:0] p1_next;
    logic [3:0] p2_next;
    logic [1:0] winner_next;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;

    assign p1_inc = p1_score + 4'd1;
    assign p2_inc = p2_score + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PLAY;
            p1_score <= 4'd0;
            p2_score <= 4'd0;
            winner   <= 2'b00;
        end else begin
            state    <= state_next;
            p1_score <= p1_next;
            p2_score <= p2_next;
            winner   <= winner_next;
        end
    end

    always_comb begin
        state_next  = state;
        p1_next     = p1_score;
        p2_next     = p2_score;
        winner_next = winner;
        if (ev_new) begin
            // New game wins over any simultaneous miss.
            state_next  = PLAY;
            p1_next     = 4'd0;
            p2_next     = 4'd0;
            winner_next = 2'b00;
        end else if (state == PLAY) begin
            // A double miss in one cycle is ambiguous and is dropped.
            if (ev_lose1 && !ev_lose2) begin
                p2_next = p2_inc;
                if (p2_inc == 4'(WIN_SCORE)) begin
                    state_next  = OVER;
                    winner_next = 2'b10;
                end
            end else if (ev_lose2 && !ev_lose1) begin
                p1_next = p1_inc;
                if (p1_inc == 4'(WIN_SCORE)) begin
                    state_next  = OVER;
                    winner_next = 2'b01;
                end
            end
        end
    end

    assign game_over = (state == OVER);
    assign dp        = 1'b1;

    // ------------------------------------------------------------------
    // Display scan: slot counter, digit index, rotation/blink counter
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_idx;
    logic [ROT_W-1:0]  rot_cnt;
    logic              blink;

    logic              scan_wrap;
    logic              rot_wrap;
    logic              blink_wrap;
    logic [1:0]        idx_next;
    logic              blink_next;
    logic [6:0]        seg_next;

    assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign rot_wrap   = scan_wrap && (digit_idx == 2'd3);
    assign blink_wrap = rot_wrap && (rot_cnt == ROT_W'(BLINK_ROT - 1));
    assign idx_next   = digit_idx + 2'd1;
    assign blink_next = blink_wrap ? ~blink : blink;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'd0:    font = 7'b1000000;
            4'd1:    font = 7'b1111001;
            4'd2:    font = 7'b0100100;
            4'd3:    font = 7'b0110000;
            4'd4:    font = 7'b0011001;
            4'd5:    font = 7'b0010010;
            4'd6:    font = 7'b0000010;
            4'd7:    font = 7'b1111000;
            4'd8:    font = 7'b0000000;
            4'd9:    font = 7'b0010000;
            default: font = SEG_BLANK;
        endcase
    endfunction

    // Segment pattern for the digit that becomes active at the next wrap,
    // using the blink flag as it will be after that wrap so the blanking
    // lines up with the rotation boundary.
    always_comb begin
        seg_next = SEG_DASH;
        case (idx_next)
            2'd3: begin
                if (state == OVER && blink_next && winner == 2'b01)
                    seg_next = SEG_BLANK;
                else
                    seg_next = font(p1_score);
            end
            2'd0: begin
                if (state == OVER && blink_next && winner == 2'b10)
                    seg_next = SEG_BLANK;
                else
                    seg_next = font(p2_score);
            end
            default: seg_next = SEG_DASH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            rot_cnt   <= '0;
            blink     <= 1'b0;
            an        <= 4'b1110;
            seg       <= 7'b1000000;
        end else begin
            if (scan_wrap) begin
                scan_cnt  <= '0;
                digit_idx <= idx_next;
                an        <= ~(4'b0001 << idx_next);
                seg       <= seg_next;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            if (rot_wrap) begin
                rot_cnt <= blink_wrap ? '0 : rot_cnt + ROT_W'(1);
            end
            blink <= blink_next;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper

module tb_score_keeper;

    logic       clk;
    logic       rst;
    logic       lose1;
    logic       lose2;
    logic       new_game;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       game_over;
    logic [1:0] winner;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_pass  = 0;
    int n_total = 0;

    score_keeper #(
        .WIN_SCORE(3),
        .SCAN_DIV (4),
        .BLINK_ROT(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lose1    (lose1),
        .lose2    (lose2),
        .new_game (new_game),
        .p1_score (p1_score),
        .p2_score (p2_score),
        .game_over(game_over),
        .winner   (winner),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the given inputs high for 'hold' cycles, then idle long enough
    // for the synchronisers to settle.
    task automatic drive(input logic l1, input logic l2, input logic ng, input int hold);
        lose1    = l1;
        lose2    = l2;
        new_game = ng;
        repeat (hold) @(negedge clk);
        lose1    = 1'b0;
        lose2    = 1'b0;
        new_game = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; lose1 = 1'b1; lose2 = 1'b0; new_game = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (p1_score !== 4'd0) $display("FAIL rst_p1: got %0d want 0", p1_score); else n_pass++;
        n_total++; if (p2_score !== 4'd0) $display("FAIL rst_p2: got %0d want 0", p2_score); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL rst_go: got %b want 0", game_over); else n_pass++;
        n_total++; if (winner !== 2'b00) $display("FAIL rst_winner: got %b want 00", winner); else n_pass++;
        n_total++; if (an !== 4'b1110) $display("FAIL rst_an: got %b want 1110", an); else n_pass++;
        n_total++; if (seg !== 7'b1000000) $display("FAIL rst_seg: got %b want 1000000", seg); else n_pass++;
        n_total++; if (dp !== 1'b1) $display("FAIL rst_dp: got %b want 1", dp); else n_pass++;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_total++; if (p2_score !== 4'd0) $display("FAIL held_lose1_p2: got %0d want 0", p2_score); else n_pass++;
        lose1 = 1'b0;
        repeat (4) @(negedge clk);
        n_total++; if (p2_score !== 4'd0) $display("FAIL released_lose1_p2: got %0d want 0", p2_score); else n_pass++;
    endtask

    task automatic test_lose2_pulse;
        lose2 = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (p1_score !== 4'd0) $display("FAIL lose2_edge2_p1: got %0d want 0", p1_score); else n_pass++;
        @(negedge clk);
        n_total++; if (p1_score !== 4'd1) $display("FAIL lose2_edge3_p1: got %0d want 1", p1_score); else n_pass++;
        lose2 = 1'b0;
        repeat (4) @(negedge clk);
        n_total++; if (p1_score !== 4'd1) $display("FAIL lose2_hold_p1: got %0d want 1", p1_score); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 3);
        n_total++; if (p1_score !== 4'd2) $display("FAIL lose2_second_p1: got %0d want 2", p1_score); else n_pass++;
        n_total++; if (p2_score !== 4'd0) $display("FAIL lose2_second_p2: got %0d want 0", p2_score); else n_pass++;
    endtask

    task automatic test_simultaneous;
        drive(1'b1, 1'b1, 1'b0, 5);
        n_total++; if (p1_score !== 4'd2) $display("FAIL both_p1: got %0d want 2", p1_score); else n_pass++;
        n_total++; if (p2_score !== 4'd0) $display("FAIL both_p2: got %0d want 0", p2_score); else n_pass++;
    endtask

    task automatic test_win;
        drive(1'b1, 1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 1'b0, 3);
        n_total++; if (p2_score !== 4'd2) $display("FAIL win_pre_p2: got %0d want 2", p2_score); else n_pass++;
        lose1 = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (game_over !== 1'b0) $display("FAIL win_edge2_go: got %b want 0", game_over); else n_pass++;
        @(negedge clk);
        n_total++; if (p2_score !== 4'd3) $display("FAIL win_p2: got %0d want 3", p2_score); else n_pass++;
        n_total++; if (game_over !== 1'b1) $display("FAIL win_go: got %b want 1", game_over); else n_pass++;
        n_total++; if (winner !== 2'b10) $display("FAIL win_winner: got %b want 10", winner); else n_pass++;
        lose1 = 1'b0;
        repeat (4) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 3);
        n_total++; if (p2_score !== 4'd3) $display("FAIL over_lose1_p2: got %0d want 3", p2_score); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 3);
        n_total++; if (p1_score !== 4'd2) $display("FAIL over_lose2_p1: got %0d want 2", p1_score); else n_pass++;
        n_total++; if (game_over !== 1'b1) $display("FAIL over_go: got %b want 1", game_over); else n_pass++;
    endtask

    task automatic test_scan_blink;
        logic [3:0] exp_an [4];
        logic [6:0] exp_seg [4];
        logic [6:0] v [8];
        logic [3:0] prev;
        logic [3:0] held;
        bit         found;
        exp_an[0] = 4'b1101; exp_seg[0] = 7'b0111111;
        exp_an[1] = 4'b1011; exp_seg[1] = 7'b0111111;
        exp_an[2] = 4'b0111; exp_seg[2] = 7'b0100100;
        exp_an[3] = 4'b1110;
        exp_seg[3] = 7'b0110000;
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev !== 4'b1110 && an === 4'b1110) found = 1'b1;
            prev = an;
        end
        n_total++; if (!found) $display("FAIL scan_find_digit0: got timeout want an=1110 within 40 cycles"); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            held = an;
            repeat (3) @(negedge clk);
            n_total++; if (an !== held) $display("FAIL scan_hold_%0d: got %b want %b", k, an, held); else n_pass++;
            @(negedge clk);
            n_total++; if (an !== exp_an[k]) $display("FAIL scan_an_%0d: got %b want %b", k, an, exp_an[k]); else n_pass++;
            if (k < 3) begin
                n_total++; if (seg !== exp_seg[k]) $display("FAIL scan_seg_%0d: got %b want %b", k, seg, exp_seg[k]); else n_pass++;
            end
        end
        // Now at the start of a digit-0 slot; sample that slot over 8 rotations.
        for (int k = 0; k < 8; k++) begin
            v[k] = seg;
            n_total++;
            if (an !== 4'b1110 || (v[k] !== exp_seg[3] && v[k] !== 7'b1111111))
                $display("FAIL blink_value_%0d: got an=%b seg=%b want an=1110 seg=0110000 or 1111111", k, an, v[k]);
            else n_pass++;
            repeat (16) @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            n_total++;
            if (v[k] === v[k+2]) $display("FAIL blink_period_%0d: got seg=%b twice two rotations apart want alternation", k, v[k]);
            else n_pass++;
        end
    endtask

    task automatic test_new_game_priority;
        drive(1'b1, 1'b0, 1'b1, 4);
        n_total++; if (p1_score !== 4'd0) $display("FAIL ng_p1: got %0d want 0", p1_score); else n_pass++;
        n_total++; if (p2_score !== 4'd0) $display("FAIL ng_p2: got %0d want 0", p2_score); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL ng_go: got %b want 0", game_over); else n_pass++;
        n_total++; if (winner !== 2'b00) $display("FAIL ng_winner: got %b want 00", winner); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 3);
        n_total++; if (p1_score !== 4'd1) $display("FAIL ng_play_p1: got %0d want 1", p1_score); else n_pass++;
    endtask

    task automatic test_reset_midgame;
        lose2 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (p1_score !== 4'd0) $display("FAIL midrst_async_p1: got %0d want 0", p1_score); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_total++; if (p1_score !== 4'd0) $display("FAIL midrst_after_p1: got %0d want 0", p1_score); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL midrst_go: got %b want 0", game_over); else n_pass++;
        lose2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; lose1 = 1'b0; lose2 = 1'b0; new_game = 1'b0;
        test_reset;
        test_lose2_pulse;
        test_simultaneous;
        test_win;
        test_scan_blink;
        test_new_game_priority;
        test_reset_midgame;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 9, is the score (1..9) at which a player wins.
REQ-002 Parameter SCAN_DIV, default 100000, is the number of clk cycles per 7-segment digit slot (1 ms at 100 MHz).
REQ-003 Parameter BLINK_ROT, default 128, is the number of full 4-digit scan rotations per blink half-period.
REQ-004 clk  in  1  system clock, 100 MHz; the only clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 lose1  in  1  level from the VGA display stage; high means player 1 missed; produced in the vs domain and treated as asynchronous.
REQ-007 lose2  in  1  as lose1, for player 2.
REQ-008 new_game  in  1  raw push-button level, asynchronous; a rising edge starts a new game.
REQ-009 p1_score  out  4  player 1 score, binary 0..WIN_SCORE.
REQ-010 p2_score  out  4  player 2 score, binary 0..WIN_SCORE.
REQ-011 game_over  out  1  high while in state OVER.
REQ-012 winner  out  2  01 = player 1 won, 10 = player 2 won, 00 = no winner.
REQ-013 an  out  4  7-segment anodes, active-low, one-hot.
REQ-014 seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-015 dp  out  1  decimal point, active-low; held 1.

Function
REQ-016 Each of lose1, lose2 and new_game shall pass through a 2-flop synchronizer followed by a history flop; an event is sync_out=1 AND history=0.
REQ-017 A registered counter shall be updated on the third rising clk edge after its input goes high; an input must be held for at least 3 cycles.
REQ-018 A lose1 event shall increment p2_score by 1, and a lose2 event shall increment p1_score by 1.
REQ-019 If lose1 and lose2 events occur in the same cycle, both shall be discarded and neither score shall change.
REQ-020 The FSM states shall be PLAY and OVER.
REQ-021 In PLAY, when an increment would make a score equal to WIN_SCORE, the score shall be written, the state shall go to OVER in the same edge, and game_over and winner shall become valid in that same edge.
REQ-022 In OVER, lose events shall be ignored and scores shall hold; scores shall never exceed WIN_SCORE.
REQ-023 A new_game event, in either state, shall clear both scores, set winner=00 and enter PLAY.
REQ-024 If new_game and lose events occur in the same cycle, new_game shall take priority.
REQ-025 Scan counter:
  - 0..SCAN_DIV-1; on wrap, the digit index shall advance 0 -> 1 -> 2 -> 3 -> 0.
  - an = ~(1 << index).
REQ-026 Digit content:
  - index 3 = p1_score, index 0 = p2_score.
  - indices 2 and 1 show a dash (seg = 0111111).
REQ-027 Hex font:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Values >9 shall be blank (1111111).
REQ-028 Blink:
  - A rotation counter shall toggle a blink flag every BLINK_ROT rotations (index 3 -> 0 wraps).
  - In OVER with the flag high, the winner's digit shall be blank; otherwise it is shown.
  - In PLAY the flag shall have no effect.
REQ-029 an and seg shall be registered and change only on a scan-counter wrap or reset.

Reset
REQ-030 Asserting rst low shall immediately set:
  - p1_score = 0, p2_score = 0, state = PLAY, game_over = 0, winner = 00.
  - scan counter = 0, index = 0, blink flag = 0.
  - an = 1110, seg = 1000000, dp = 1.
REQ-031 Synchronizer and history flops shall reset to 1, so an input held high across reset release produces no event.
REQ-032 Reset asserted mid-game or in OVER shall discard all pending events, with no increment after release.

Verification
REQ-033 Reset with lose1 = 1 held through release -> no event; p2_score stays 0.
REQ-034 Pulse lose2 high for 3 clk -> p1_score goes 0 -> 1 on the 3rd edge; further pulses each add exactly 1.
REQ-035 Assert lose1 and lose2 together for 5 clk -> both scores unchanged.
REQ-036 With WIN_SCORE = 3, give 3 lose1 events:
  - p2_score = 3, game_over = 1 and winner = 10 on the same edge.
  - A 4th lose1 leaves p2_score = 3.
REQ-037 With SCAN_DIV = 4, BLINK_ROT = 2, in OVER with winner = 10:
  - an cycles 1110, 1101, 1011, 0111, changing every 4 clk.
  - The digit-0 seg alternates 0110000 / 1111111 every 2 rotations.
REQ-038 In OVER, a new_game rising edge together with a lose1 pulse:
  - Scores become 0/0, game_over = 0, winner = 00.
  - No increment is applied.
